axi_wr_burst_master: RTL and testbench
======================================

// Module: axi_wr_burst_master
// PURPOSE
//  Parametrised AXI write master for the DDR2 controller front end. Accepts one user write request of up to
//  2^LEN_WIDTH-1 beats and splits it into AXI bursts of at most MAX_BURST beats, none crossing a DDR row.
//  AW and W run decoupled, with up to MAX_OUTSTANDING bursts awaiting B. Byte strobes and BRESP errors are supported.
// PARAMETERS
//  ADDR_WIDTH       26  beat (word) address width
//  DATA_WIDTH       32  data width in bits; multiple of 8
//  LEN_WIDTH        16  request length width, in beats
//  MAX_BURST        16  max beats per AXI burst; power of 2, 1..256
//  COL_BITS         10  column bits; a burst never crosses a 2^COL_BITS-beat boundary
//  MAX_OUTSTANDING   4  max AW-accepted bursts without B response; power of 2, >=1
// PORTS
//  clk          in   1             clock; all logic on rising edge
//  rst_n        in   1             asynchronous active-low reset
//  init_end     in   1             DDR init complete; requests ignored while low
//  wr_trig      in   1             request strobe; accepted only when wr_ready=1
//  wr_addr      in   ADDR_WIDTH    request start beat address, sampled on accept
//  wr_len       in   LEN_WIDTH     request beat count (not minus 1)
//  wr_data      in   DATA_WIDTH    write data, passed straight to axi_wdata
//  wr_strb      in   DATA_WIDTH/8  byte enables, passed straight to axi_wstrb
//  wr_data_en   out  1             beat consumed this cycle (axi_wvalid & axi_wready); user advances data
//  wr_ready     out  1             idle and init_end=1
//  wr_done      out  1             one-cycle pulse: request fully written and acknowledged
//  wr_err       out  1             valid with wr_done: some BRESP != OKAY
//  axi_awvalid/axi_awready  out/in  1     AW handshake
//  axi_awaddr   out  ADDR_WIDTH    burst start beat address
//  axi_awlen    out  8             beats-1
//  axi_wvalid/axi_wready    out/in  1     W handshake
//  axi_wdata    out  DATA_WIDTH    = wr_data
//  axi_wstrb    out  DATA_WIDTH/8  = wr_strb
//  axi_wlast    out  1             last beat of current burst
//  axi_bvalid   in   1             B valid
//  axi_bresp    in   2             00=OKAY, anything else is an error
//  axi_bready   out  1             high whenever outstanding count > 0
// BEHAVIOUR
//  Reset (async, immediate): all valids low; awaddr, awlen, counters 0; wr_done, wr_err 0; FSMs IDLE.
//   Reset mid-request discards the request: no wr_done, and the FIFO and counters are cleared.
//  AW FSM states: IDLE -> CALC -> ISSUE -> (CALC | WAIT_DONE) -> IDLE.
//   IDLE: wr_ready=init_end. On wr_trig&wr_ready, latch addr/len, clear wr_err, go to CALC.
//    If wr_len=0, skip to a wr_done pulse the next cycle (wr_err=0).
//   CALC (1 cycle): beats = min(remaining, MAX_BURST, 2^COL_BITS - addr[COL_BITS-1:0]); awlen=beats-1.
//   ISSUE: awvalid=1 only while outstanding<MAX_OUTSTANDING and the len FIFO is not full.
//    Once high, awvalid/awaddr/awlen stay stable until awready.
//    On the handshake: push beats to the len FIFO, outstanding++, addr+=beats (mod 2^ADDR_WIDTH),
//    remaining-=beats. Go to CALC if remaining>0, else WAIT_DONE.
//   WAIT_DONE: when W is idle, the FIFO is empty and outstanding=0, pulse wr_done for 1 cycle -> IDLE.
//  Latency: trig accepted at cycle T; awvalid first high at T+2 when not stalled.
//  W channel: when idle and the FIFO is non-empty, pop and load the beat counter. wvalid rises the next cycle.
//   Each wvalid&wready decrements the counter; wlast=(counter==1). W bursts run only for AW-accepted bursts, in order.
//   After a wlast handshake with the FIFO still non-empty, the next burst starts back-to-back (no bubble).
//  B: bresp is sampled on bvalid&bready; a non-OKAY response sets wr_err sticky until the next accept.
//   AW handshake and B handshake in the same cycle leave outstanding unchanged.
//  A wr_trig while busy is ignored (no queueing).
// STRUCTURE
//  Shared header axi_defs.vh: AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, AXI_BURST_INCR.
//  Sub-module wr_burst_fifo: sync FIFO, depth MAX_OUTSTANDING, 9-bit entries (beat count), full/empty flags.
//  Remaining logic: AW FSM, W beat counter, outstanding counter, done/err logic, in this file.
// TESTING
//  1 addr=0x000, len=8: one AW (addr 0x000, awlen 7), 8 W beats, wlast on beat 8, wr_done x1, wr_err=0.
//  2 addr=0x3F8, len=20, COL_BITS=10: AW 0x3F8/awlen 7, then 0x400/awlen 11; 20 wr_data_en pulses.
//  3 addr=0, len=40, MAX_OUTSTANDING=2, bvalid held off: bursts of 16,16,8; 3rd awvalid stays low until 1st B.
//  4 Random wready, awready delayed 5 cycles: awvalid/awaddr stable while waiting; 40 beats in order; no beat lost.
//  5 bresp=2'b10 on burst 2 of 3: wr_done with wr_err=1; next request with OKAY responses ends with wr_err=0.
//  6 wr_trig with init_end=0 is ignored. rst_n low mid-burst clears outputs with no clk edge. len=0 gives wr_done, no AW.

Source files
------------

// File: rtl/axi_wr_burst_master_pkg.sv
// Shared types and constants for the AXI write burst master.
package axi_wr_burst_master_pkg;

    // AW-side sequencing states
    typedef enum logic [1:0] {
        AW_IDLE      = 2'd0,
        AW_CALC      = 2'd1,
        AW_ISSUE     = 2'd2,
        AW_WAIT_DONE = 2'd3
    } aw_state_e;

    // AXI write response codes
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Width of a burst beat count (1..256)
    localparam int BEAT_W = 9;

endpackage

// File: rtl/axi_wr_burst_master_fifo.sv
// Small synchronous FIFO carrying the beat count of each AW-accepted burst
// from the address side to the data side. Show-ahead read port.
module axi_wr_burst_master_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage array: written on accepted push only
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy, wrapping at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_wr_burst_master.sv
// AXI write master: splits one user request into row-safe bursts of at most
// MAX_BURST beats, with AW and W decoupled through a beat-count FIFO and up to
// MAX_OUTSTANDING bursts awaiting B.
//
// Handshakes: every channel transfers on a rising edge where valid & ready are
// both high; a raised valid and its payload hold until that edge, and valid
// never waits on ready.
module axi_wr_burst_master
    import axi_wr_burst_master_pkg::*;
#(
    parameter int ADDR_WIDTH      = 26,
    parameter int DATA_WIDTH      = 32,
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_BURST       = 16,
    parameter int COL_BITS        = 10,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    init_end,
    input  logic                    wr_trig,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [LEN_WIDTH-1:0]    wr_len,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    output logic                    wr_data_en,
    output logic                    wr_ready,
    output logic                    wr_done,
    output logic                    wr_err,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [ADDR_WIDTH-1:0]   axi_awaddr,
    output logic [7:0]              axi_awlen,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    output logic [DATA_WIDTH-1:0]   axi_wdata,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                    axi_wlast,
    input  logic                    axi_bvalid,
    input  logic [1:0]              axi_bresp,
    output logic                    axi_bready,
    output logic [1:0]              aw_state_dbg
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    aw_state_e             aw_state;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic [OUT_W-1:0]      out_cnt;
    logic [BEAT_W-1:0]     w_cnt;
    logic [BEAT_W-1:0]     burst_beats;
    logic [BEAT_W-1:0]     calc_beats;
    logic [BEAT_W-1:0]     fifo_dout;
    logic [31:0]           col_room;
    logic [31:0]           beats_lim;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;
    logic                  can_issue;

    assign aw_hs        = axi_awvalid & axi_awready;
    assign w_hs         = axi_wvalid & axi_wready;
    assign b_hs         = axi_bvalid & axi_bready;
    assign axi_bready   = (out_cnt != '0);
    assign can_issue    = (out_cnt < OUT_W'(MAX_OUTSTANDING)) & ~fifo_full;
    assign burst_beats  = {1'b0, axi_awlen} + BEAT_W'(1);
    assign wr_ready     = (aw_state == AW_IDLE) & init_end;
    assign wr_data_en   = w_hs;
    assign axi_wdata    = wr_data;
    assign axi_wstrb    = wr_strb;
    assign axi_wlast    = (w_cnt == BEAT_W'(1));
    assign aw_state_dbg = aw_state;
    assign calc_beats   = BEAT_W'(beats_lim);
    // Reload the beat counter when W is idle or finishing its last beat
    assign fifo_pop     = ~fifo_empty & ((w_cnt == '0) | (w_hs & axi_wlast));

    // Next burst size: limited by what is left, MAX_BURST and the row end
    always_comb begin
        col_room  = (32'd1 << COL_BITS) - 32'(axi_awaddr[COL_BITS-1:0]);
        beats_lim = 32'(rem_q);
        if (beats_lim > 32'(MAX_BURST)) beats_lim = 32'(MAX_BURST);
        if (beats_lim > col_room)       beats_lim = col_room;
    end

    // AW sequencer: request accept, burst sizing, address issue, completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_state    <= AW_IDLE;
            axi_awvalid <= 1'b0;
            axi_awaddr  <= '0;
            axi_awlen   <= '0;
            rem_q       <= '0;
            wr_done     <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            if (b_hs && (axi_bresp != AXI_RESP_OKAY)) begin
                wr_err <= 1'b1;
            end
            case (aw_state)
                AW_IDLE: begin
                    if (wr_trig && init_end) begin
                        wr_err     <= 1'b0;
                        axi_awaddr <= wr_addr;
                        rem_q      <= wr_len;
                        if (wr_len == '0) begin
                            wr_done <= 1'b1;
                        end else begin
                            aw_state <= AW_CALC;
                        end
                    end
                end
                AW_CALC: begin
                    axi_awlen   <= 8'(calc_beats - BEAT_W'(1));
                    axi_awvalid <= can_issue;
                    aw_state    <= AW_ISSUE;
                end
                AW_ISSUE: begin
                    if (aw_hs) begin
                        axi_awvalid <= 1'b0;
                        axi_awaddr  <= axi_awaddr + ADDR_WIDTH'(burst_beats);
                        rem_q       <= rem_q - LEN_WIDTH'(burst_beats);
                        aw_state    <= (rem_q == LEN_WIDTH'(burst_beats)) ? AW_WAIT_DONE : AW_CALC;
                    end else if (!axi_awvalid && can_issue) begin
                        axi_awvalid <= 1'b1;
                    end
                end
                AW_WAIT_DONE: begin
                    if ((w_cnt == '0) && fifo_empty && (out_cnt == '0)) begin
                        wr_done  <= 1'b1;
                        aw_state <= AW_IDLE;
                    end
                end
                default: aw_state <= AW_IDLE;
            endcase
        end
    end

    // Outstanding bursts: +1 on AW accept, -1 on B accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= '0;
        end else begin
            case ({aw_hs, b_hs})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    // W beat counter: loads from the FIFO, counts down on each data beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_cnt      <= '0;
            axi_wvalid <= 1'b0;
        end else if (fifo_pop) begin
            w_cnt      <= fifo_dout;
            axi_wvalid <= 1'b1;
        end else if (w_hs) begin
            w_cnt      <= w_cnt - BEAT_W'(1);
            axi_wvalid <= (w_cnt != BEAT_W'(1));
        end
    end

    axi_wr_burst_master_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (BEAT_W)
    ) u_len_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (aw_hs),
        .din   (burst_beats),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_axi_wr_burst_master.sv
// Bench for axi_wr_burst_master: table of directed requests, hand sequences
// for stall/reset/init corner cases, then randomized requests against a
// burst-splitting model.
module tb_axi_wr_burst_master;
  import axi_wr_burst_master_pkg::*;

  localparam int MO = 2;

  logic        clk, rst_n, init_end, wr_trig;
  logic [25:0] wr_addr;
  logic [15:0] wr_len;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_data_en, wr_ready, wr_done, wr_err;
  logic        axi_awvalid, axi_awready;
  logic [25:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic        axi_wvalid, axi_wready, axi_wlast;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid, axi_bready;
  logic [1:0]  axi_bresp;
  logic [1:0]  aw_state_dbg;

  axi_wr_burst_master #(.MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst_n(rst_n), .init_end(init_end), .wr_trig(wr_trig),
    .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_data_en(wr_data_en), .wr_ready(wr_ready), .wr_done(wr_done), .wr_err(wr_err),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp), .axi_bready(axi_bready),
    .aw_state_dbg(aw_state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard queues: {awaddr, awlen} and {wlast, wstrb, wdata}
  logic [33:0] exp_aw_q[$];
  logic [36:0] exp_w_q[$];

  // slave knobs
  int aw_delay = 0;
  bit w_rand = 0;
  bit b_hold = 0;
  int err_burst = -1;
  bit rand_err = 0;

  // observation state
  int aw_wait = 0, b_pending = 0, b_idx = 0;
  int aw_cnt = 0, b_cnt = 0, done_cnt = 0, b_at_aw3 = -1;
  bit any_err = 0, done_err = 0;
  bit aw_fire = 0, w_fire = 0, w_last_fire = 0, b_fire = 0, de_seen = 0;
  bit aw_pend = 0;
  logic [33:0] aw_hold, first_aw, model_first;
  logic [31:0] data_base = 32'h0;
  int beat_idx = 0;

  typedef struct {
    logic [25:0] addr;
    int          len;
    int          awd;
    bit          wrand;
    int          errb;
    int          nb;
    logic [25:0] a0;
    logic [7:0]  l0;
    bit          err;
  } vec_t;
  vec_t vecs[7];

  function automatic vec_t mk(logic [25:0] addr, int len, int awd, bit wrand, int errb,
                              int nb, logic [25:0] a0, logic [7:0] l0, bit err);
    vec_t v;
    v.addr = addr; v.len = len; v.awd = awd; v.wrand = wrand; v.errb = errb;
    v.nb = nb; v.a0 = a0; v.l0 = l0; v.err = err;
    return v;
  endfunction

  function automatic logic [31:0] data_of(int k);
    return data_base + 32'(k) * 32'h01010101;
  endfunction

  function automatic logic [3:0] strb_of(int k);
    logic [3:0] s;
    s = data_base[3:0] + 4'(k);
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got no/extra event, expected event in bound", name);
  endtask

  // monitor: sample at negedge, record handshakes completing at the next posedge
  always @(negedge clk) begin
    aw_fire = 0; w_fire = 0; w_last_fire = 0; b_fire = 0; de_seen = 0;
    if (!rst_n) begin
      aw_pend = 0;
    end else begin
      if (aw_pend)
        check("aw_stable", {axi_awvalid, axi_awaddr, axi_awlen}, {1'b1, aw_hold});
      aw_fire     = axi_awvalid & axi_awready;
      aw_pend     = axi_awvalid & ~axi_awready;
      aw_hold     = {axi_awaddr, axi_awlen};
      w_fire      = axi_wvalid & axi_wready;
      w_last_fire = w_fire & axi_wlast;
      b_fire      = axi_bvalid & axi_bready;
      de_seen     = wr_data_en;
      if (aw_fire) begin
        if (aw_cnt == 0) first_aw = {axi_awaddr, axi_awlen};
        if (exp_aw_q.size() == 0) fail("aw_unexpected");
        else check("aw_burst", {axi_awaddr, axi_awlen}, exp_aw_q.pop_front());
        aw_cnt++;
        if (aw_cnt == 3) b_at_aw3 = b_cnt;
      end
      if (w_fire) begin
        if (exp_w_q.size() == 0) fail("w_unexpected");
        else check("w_beat", {axi_wlast, axi_wstrb, axi_wdata}, exp_w_q.pop_front());
      end
      if (b_fire) b_cnt++;
      if (wr_done) begin
        done_cnt++;
        done_err = wr_err;
      end
    end
  end

  // driver: user data advance and AXI slave responses, just after posedge
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 2'b00;
      b_pending = 0; aw_wait = 0;
    end else begin
      if (de_seen) beat_idx++;
      wr_data = data_of(beat_idx);
      wr_strb = strb_of(beat_idx);
      if (aw_fire || !axi_awvalid) aw_wait = 0;
      else aw_wait++;
      axi_awready = (aw_wait > aw_delay);
      axi_wready = w_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (w_last_fire) b_pending++;
      if (b_fire) begin
        b_pending--;
        axi_bvalid = 0;
      end
      if (!axi_bvalid && b_pending > 0 && !b_hold) begin
        axi_bvalid = 1;
        if (b_idx == err_burst) axi_bresp = AXI_RESP_SLVERR;
        else if (rand_err && $urandom_range(0, 3) == 0) axi_bresp = AXI_RESP_DECERR;
        else axi_bresp = AXI_RESP_OKAY;
        if (axi_bresp != AXI_RESP_OKAY) any_err = 1;
        b_idx++;
      end
    end
  end

  // build expectations from the splitting rules, then issue the request
  task automatic do_request(input logic [25:0] addr, input int len);
    logic [25:0] a;
    int rem, b, k, col, cnt;
    data_base = $urandom;
    beat_idx = 0;
    wr_data = data_of(0);
    wr_strb = strb_of(0);
    a = addr; rem = len; k = 0;
    model_first = '0;
    while (rem > 0) begin
      col = int'(a) % 1024;
      b = rem;
      if (b > 16) b = 16;
      if (b > 1024 - col) b = 1024 - col;
      if (k == 0) model_first = {a, 8'(b - 1)};
      exp_aw_q.push_back({a, 8'(b - 1)});
      for (int i = 0; i < b; i++) begin
        exp_w_q.push_back({(i == b - 1), strb_of(k), data_of(k)});
        k++;
      end
      a = a + 26'(b);
      rem -= b;
    end
    aw_cnt = 0; b_cnt = 0; done_cnt = 0; b_idx = 0; any_err = 0; b_at_aw3 = -1;
    @(posedge clk); #1;
    cnt = 0;
    while (!wr_ready && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!wr_ready) fail("ready_timeout");
    wr_addr = addr;
    wr_len = 16'(len);
    wr_trig = 1;
    @(posedge clk); #1;
    wr_trig = 0;
    if (len == 0) check("zero_len_done", wr_done, 1);
    else check("accept_busy", {wr_ready, axi_awvalid}, 2'b00);
    @(posedge clk); #1;
    if (len == 0) check("zero_len_pulse", wr_done, 0);
    else check("aw_latency", axi_awvalid, 1);
  endtask

  // exp_err < 0 means: use the responses the slave actually gave
  task automatic wait_done(input string name, input int exp_err, input int exp_nb,
                           input logic [33:0] exp_first);
    int cnt = 0;
    while (done_cnt == 0 && cnt < 3000) begin
      @(posedge clk);
      cnt++;
    end
    if (done_cnt == 0) fail({name, "_done_timeout"});
    repeat (5) @(posedge clk);
    #1;
    check({name, "_done_once"}, 64'(done_cnt), 1);
    check({name, "_err"}, 64'(done_err), (exp_err < 0) ? 64'(any_err) : 64'(exp_err));
    check({name, "_aw_count"}, 64'(aw_cnt), 64'(exp_nb));
    if (exp_nb > 0) check({name, "_first_aw"}, 64'(first_aw), 64'(exp_first));
    check({name, "_queues_empty"}, 64'(exp_aw_q.size() + exp_w_q.size()), 0);
  endtask

  initial begin
    int cnt;
    vecs[0] = mk(26'h000,     8,  0, 0, -1, 1, 26'h000,     8'd7,  0);
    vecs[1] = mk(26'h3F8,     20, 0, 0, -1, 2, 26'h3F8,     8'd7,  0);
    vecs[2] = mk(26'h000,     40, 5, 1, -1, 3, 26'h000,     8'd15, 0);
    vecs[3] = mk(26'h000,     48, 0, 0,  1, 3, 26'h000,     8'd15, 1);
    vecs[4] = mk(26'h100,     24, 0, 0, -1, 2, 26'h100,     8'd15, 0);
    vecs[5] = mk(26'h3FF,     3,  1, 1, -1, 2, 26'h3FF,     8'd0,  0);
    vecs[6] = mk(26'h3FFFFF0, 20, 0, 0, -1, 2, 26'h3FFFFF0, 8'd15, 0);

    rst_n = 1; init_end = 1; wr_trig = 0; wr_addr = '0; wr_len = '0;
    wr_data = '0; wr_strb = '0;
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 2'b00;
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {axi_awvalid, axi_wvalid, axi_bready, wr_done, wr_err,
                          axi_awaddr, axi_awlen, aw_state_dbg}, '0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    check("ready_after_reset", wr_ready, 1);

    // directed table
    for (int i = 0; i < 7; i++) begin
      aw_delay = vecs[i].awd; w_rand = vecs[i].wrand; err_burst = vecs[i].errb;
      rand_err = 0; b_hold = 0;
      do_request(vecs[i].addr, vecs[i].len);
      wait_done($sformatf("vec%0d", i), int'(vecs[i].err), vecs[i].nb, {vecs[i].a0, vecs[i].l0});
    end

    // outstanding limit: third AW held back until a B arrives
    aw_delay = 0; w_rand = 0; err_burst = -1; b_hold = 1;
    do_request(26'h000, 40);
    cnt = 0;
    while (exp_w_q.size() > 8 && cnt < 500) begin
      @(posedge clk);
      cnt++;
    end
    if (exp_w_q.size() > 8) fail("stall_w_timeout");
    repeat (10) @(posedge clk);
    #1;
    check("stall_aw", {32'(aw_cnt), axi_awvalid}, {32'd2, 1'b0});
    b_hold = 0;
    wait_done("stall", 0, 3, {26'h000, 8'd15});
    check("b_before_aw3", 64'(b_at_aw3 >= 1), 1);

    // requests ignored while init_end is low
    init_end = 0;
    @(posedge clk); #1;
    check("init_low_ready", wr_ready, 0);
    aw_cnt = 0; done_cnt = 0;
    wr_addr = 26'h40; wr_len = 16'd4; wr_trig = 1;
    repeat (3) @(posedge clk);
    #1 wr_trig = 0;
    repeat (5) @(posedge clk);
    #1;
    check("init_low_ignored", {32'(aw_cnt + done_cnt), axi_awvalid, aw_state_dbg}, '0);
    init_end = 1;

    // asynchronous reset in the middle of a burst
    do_request(26'h020, 40);
    cnt = 0;
    while (exp_w_q.size() >= 30 && cnt < 300) begin
      @(posedge clk);
      cnt++;
    end
    if (exp_w_q.size() >= 30) fail("midreset_w_timeout");
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("async_reset", {axi_awvalid, axi_wvalid, axi_bready, wr_done, wr_err, wr_data_en,
                          axi_awaddr, axi_awlen, aw_state_dbg}, '0);
    repeat (3) @(posedge clk);
    exp_aw_q.delete();
    exp_w_q.delete();
    done_cnt = 0;
    @(negedge clk) rst_n = 1;
    repeat (10) @(posedge clk);
    #1;
    check("after_midreset", {32'(done_cnt), wr_ready, axi_bready, axi_wvalid, aw_state_dbg},
          {32'd0, 1'b1, 1'b0, 1'b0, 2'b00});

    // zero-length request
    do_request(26'h055, 0);
    wait_done("zero_len", 0, 0, '0);

    // randomized requests against the splitting model
    for (int r = 0; r < 10; r++) begin
      logic [25:0] a;
      int len;
      a = ($urandom_range(0, 1) == 1) ? 26'($urandom) : 26'(32'h3E0 + $urandom_range(0, 63));
      len = $urandom_range(1, 60);
      aw_delay = $urandom_range(0, 3);
      w_rand = 1'($urandom_range(0, 1));
      err_burst = -1;
      rand_err = 1;
      b_hold = 0;
      do_request(a, len);
      wait_done($sformatf("rand%0d", r), -1, exp_aw_q.size() + aw_cnt, model_first);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
